dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter AW, default 32, meaning memory address width.
REQ-002 SHALL have parameter DW, default 32, meaning memory data width.
REQ-003 SHALL have parameter LW, default 8, meaning vector burst element-count width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port i_stall, input, 1 bit: external stall; while high, no new memory access is issued.
REQ-007 SHALL have scalar inputs i_s_req (1), i_s_we (1), i_s_addr (AW) and i_s_wdata (DW): the scalar MEM-stage access.
REQ-008 SHALL have scalar outputs o_s_gnt (1) and o_s_stall (1): access accepted this cycle, and pipeline must hold.
REQ-009 SHALL have vector inputs i_v_start (1), i_v_we (1), i_v_base (AW), i_v_stride (AW), i_v_len (LW) and i_v_wdata (DW).
REQ-010 SHALL have vector outputs o_v_wack (1), o_v_rvalid (1), o_v_rdata (DW), o_v_busy (1) and o_v_done (1).
REQ-011 SHALL have memory outputs o_mem_en (1), o_mem_we (1), o_mem_addr (AW) and o_mem_wdata (DW), plus input i_mem_rdata (DW), valid exactly 1 cycle after a read.

Function
REQ-012 SHALL implement the FSM states IDLE, VBURST, VDRAIN and VDONE.
REQ-013 SHALL, in IDLE, route i_s_req combinationally to memory with o_s_gnt=1 in the same cycle, unless i_stall is high or the vector unit wins arbitration.
REQ-014 SHALL, when i_s_req and i_v_start are both high in IDLE, grant the requester not granted last (round-robin flag, reset to favour scalar); the loser is stalled.
REQ-015 SHALL, on accepting i_v_start, latch base, stride, len and we; set element counter k=0; and enter VBURST (or VDONE directly if len=0).
REQ-016 SHALL, in VBURST, each non-stalled cycle issue element k at o_mem_addr = base + k*stride (modulo 2^AW) and increment k.
REQ-017 SHALL assert o_v_wack during vector writes in the cycle i_v_wdata is consumed.
REQ-018 SHALL, after issuing element len-1, go to VDRAIN for a read burst, or to VDONE for a write burst.
REQ-019 SHALL assert o_v_rvalid with o_v_rdata=i_mem_rdata one cycle after each vector read, in issue order; VDRAIN lasts exactly 1 cycle.
REQ-020 SHALL pulse o_v_done for exactly 1 cycle in VDONE, then return to IDLE.
REQ-021 SHALL make a vector burst non-preemptible: o_s_stall = i_s_req whenever the state is not IDLE; o_v_busy=1 in VBURST, VDRAIN and VDONE.
REQ-022 SHALL, while i_stall is high, drive o_mem_en=0 and hold k and the state; a pending VDRAIN read return is still delivered.
REQ-023 SHALL ignore i_v_start when not in IDLE.
REQ-024 SHALL drive o_mem_we=0 and o_mem_wdata=0 whenever o_mem_en=0.

Reset
REQ-025 SHALL, on rst, set state=IDLE, k=0 and the round-robin flag to favour scalar.
REQ-026 SHALL, on rst, drive all outputs to 0 in the following cycle.
REQ-027 SHALL, on reset mid-burst, abandon the burst without o_v_done and without any further o_v_rvalid.

Structure
REQ-028 SHALL place the state enum and the default AW, DW and LW constants in a shared package, dmem_arb_pkg.
REQ-029 SHALL contain one sub-module, vaddr_gen: an element counter plus a base+stride accumulator that adds stride each issue (no multiplier).

Verification
REQ-030 SHALL cover scalar-only: i_s_req=1, read of addr 0x100 -> o_s_gnt=1 and o_mem_en=1 at addr 0x100 in the same cycle, o_s_stall=0.
REQ-031 SHALL cover a vector read: base=0x1000, stride=4, len=4 -> addrs 0x1000, 0x1004, 0x1008, 0x100C on 4 consecutive cycles; 4 o_v_rvalid pulses each lagging by 1 cycle; o_v_done 1 cycle after the last rvalid.
REQ-032 SHALL cover a collision: i_s_req and i_v_start both high from reset -> scalar granted first; on the next simultaneous request the vector unit is granted and the scalar stalls for len+2 cycles.
REQ-033 SHALL cover i_stall: i_stall high for 3 cycles during a len=4 write burst at element 2 -> no o_mem_en for 3 cycles, addr resumes at base+8, exactly 4 o_v_wack pulses in total.
REQ-034 SHALL cover len=0: i_v_start with len=0 -> no o_mem_en, o_v_done 1 cycle later.
REQ-035 SHALL cover reset mid-burst: rst during element 1 of a len=8 read -> next cycle all outputs 0, no o_v_done, state IDLE.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// ---------------------------------------------------------------------------
// dmem_arb_pkg
// Shared definitions for the data-memory arbiter that sits between the scalar
// MEM stage and the vector load/store unit.
//   DEF_AW / DEF_DW / DEF_LW : default address, data and burst-length widths
//   arb_state_t              : arbiter FSM states
// ---------------------------------------------------------------------------
package dmem_arb_pkg;

   localparam int DEF_AW = 32;
   localparam int DEF_DW = 32;
   localparam int DEF_LW = 8;

   // IDLE   : scalar traffic flows straight through, vector bursts may start
   // VBURST : one vector element issued per non-stalled cycle
   // VDRAIN : the last read of a vector burst is returning
   // VDONE  : one-cycle completion pulse before handing the port back
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      VBURST = 2'd1,
      VDRAIN = 2'd2,
      VDONE  = 2'd3
   } arb_state_t;

endpackage

// File: rtl/vaddr_gen.sv
// ---------------------------------------------------------------------------
// vaddr_gen
// Vector element address generator. Holds the element counter and a running
// address that starts at the burst base and is advanced by the stride on every
// issued element, so no multiplier is needed for base + k*stride.
// Ports:
//   clk, rst      : clock and synchronous active-high reset
//   load          : capture base/stride and restart the counter at 0
//   step          : one element was issued; advance address and counter
//   base, stride  : burst parameters, sampled when load is high
//   addr          : address of the element that will be issued next
//   k             : index of the element that will be issued next
// ---------------------------------------------------------------------------
module vaddr_gen
   import dmem_arb_pkg::*;
#(
   parameter int AW = DEF_AW,
   parameter int LW = DEF_LW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic          step,
   input  logic [AW-1:0] base,
   input  logic [AW-1:0] stride,
   output logic [AW-1:0] addr,
   output logic [LW-1:0] k
);

   logic [AW-1:0] stride_q;

   // The accumulator wraps naturally at 2^AW, which gives the modulo address
   // arithmetic for free. Load has priority so a new burst always starts clean.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr     <= '0;
         stride_q <= '0;
         k        <= '0;
      end else if (load) begin
         addr     <= base;
         stride_q <= stride;
         k        <= '0;
      end else if (step) begin
         addr     <= addr + stride_q;
         k        <= k + LW'(1);
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
// Shares one single-ported data memory between the scalar MEM stage and a
// strided vector load/store unit. Scalar accesses pass through combinationally
// while idle; a vector burst, once started, owns the port until it completes.
// Ports:
//   clk, rst                         : clock, synchronous active-high reset
//   i_stall                          : external stall, blocks any new access
//   i_s_req/i_s_we/i_s_addr/i_s_wdata: scalar access request
//   o_s_gnt, o_s_stall               : scalar accepted / scalar must hold
//   i_v_start/i_v_we/i_v_base/i_v_stride/i_v_len/i_v_wdata : vector burst
//   o_v_wack                         : vector write data consumed this cycle
//   o_v_rvalid, o_v_rdata            : vector read data return
//   o_v_busy, o_v_done               : burst in progress / burst finished
//   o_mem_en/o_mem_we/o_mem_addr/o_mem_wdata, i_mem_rdata : memory port,
//                                      read data valid one cycle after a read
// ---------------------------------------------------------------------------
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int AW = DEF_AW,
   parameter int DW = DEF_DW,
   parameter int LW = DEF_LW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_stall,
   input  logic          i_s_req,
   input  logic          i_s_we,
   input  logic [AW-1:0] i_s_addr,
   input  logic [DW-1:0] i_s_wdata,
   output logic          o_s_gnt,
   output logic          o_s_stall,
   input  logic          i_v_start,
   input  logic          i_v_we,
   input  logic [AW-1:0] i_v_base,
   input  logic [AW-1:0] i_v_stride,
   input  logic [LW-1:0] i_v_len,
   input  logic [DW-1:0] i_v_wdata,
   output logic          o_v_wack,
   output logic          o_v_rvalid,
   output logic [DW-1:0] o_v_rdata,
   output logic          o_v_busy,
   output logic          o_v_done,
   output logic          o_mem_en,
   output logic          o_mem_we,
   output logic [AW-1:0] o_mem_addr,
   output logic [DW-1:0] o_mem_wdata,
   input  logic [DW-1:0] i_mem_rdata
);

   arb_state_t    state;
   arb_state_t    state_nxt;
   logic          we_q;
   logic [LW-1:0] len_q;
   logic          rd_pending;
   logic          prio_vec;
   logic          v_win;
   logic          s_grant;
   logic          v_accept;
   logic          v_issue;
   logic          v_last;
   logic [AW-1:0] v_addr;
   logic [LW-1:0] k;

   vaddr_gen #(
      .AW (AW),
      .LW (LW)
   ) u_vaddr_gen (
      .clk    (clk),
      .rst    (rst),
      .load   (v_accept),
      .step   (v_issue),
      .base   (i_v_base),
      .stride (i_v_stride),
      .addr   (v_addr),
      .k      (k)
   );

   // Element len-1 is the last one; a zero-length burst never reaches VBURST,
   // so len_q is always at least 1 whenever this matters.
   assign v_last = (k == len_q - LW'(1));

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Burst bookkeeping. rd_pending marks that a vector read went out this
   // cycle, so its data comes back next cycle; clearing it on reset is what
   // suppresses any further rvalid from an abandoned burst. prio_vec is the
   // round-robin flag: it points at whichever requester was not served last
   // and starts out favouring the scalar side.
   always_ff @(posedge clk) begin
      if (rst) begin
         we_q       <= 1'b0;
         len_q      <= '0;
         rd_pending <= 1'b0;
         prio_vec   <= 1'b0;
      end else begin
         rd_pending <= v_issue && !we_q;
         if (v_accept) begin
            we_q  <= i_v_we;
            len_q <= i_v_len;
         end
         if (s_grant) begin
            prio_vec <= 1'b1;
         end else if (v_accept) begin
            prio_vec <= 1'b0;
         end
      end
   end

   // Next-state and output decode. Everything defaults to zero, and the whole
   // decode is skipped while rst is high so the outputs are quiet during and
   // right after reset regardless of what the requesters are doing. In IDLE a
   // vector start only wins against a simultaneous scalar request when the
   // round-robin flag points at it, and neither side is accepted while the
   // external stall is up. Only VBURST waits on i_stall: VDRAIN and VDONE
   // issue nothing, so the pending read still returns and done stays a single
   // pulse. The memory write-data bus is zeroed for reads and idle cycles.
   always_comb begin
      state_nxt   = state;
      v_win       = 1'b0;
      s_grant     = 1'b0;
      v_accept    = 1'b0;
      v_issue     = 1'b0;
      o_s_gnt     = 1'b0;
      o_s_stall   = 1'b0;
      o_v_wack    = 1'b0;
      o_v_rvalid  = 1'b0;
      o_v_rdata   = '0;
      o_v_busy    = 1'b0;
      o_v_done    = 1'b0;
      o_mem_en    = 1'b0;
      o_mem_we    = 1'b0;
      o_mem_addr  = '0;
      o_mem_wdata = '0;

      if (!rst) begin
         o_v_rvalid = rd_pending;
         o_v_rdata  = rd_pending ? i_mem_rdata : '0;
         o_v_busy   = (state != IDLE);

         unique case (state)
            IDLE: begin
               v_win = i_v_start && (!i_s_req || prio_vec);
               if (!i_stall) begin
                  if (v_win) begin
                     v_accept  = 1'b1;
                     state_nxt = (i_v_len == '0) ? VDONE : VBURST;
                  end else if (i_s_req) begin
                     s_grant     = 1'b1;
                     o_mem_en    = 1'b1;
                     o_mem_we    = i_s_we;
                     o_mem_addr  = i_s_addr;
                     o_mem_wdata = i_s_we ? i_s_wdata : '0;
                  end
               end
               o_s_gnt   = s_grant;
               o_s_stall = i_s_req && !s_grant;
            end

            VBURST: begin
               o_s_stall = i_s_req;
               if (!i_stall) begin
                  v_issue     = 1'b1;
                  o_mem_en    = 1'b1;
                  o_mem_we    = we_q;
                  o_mem_addr  = v_addr;
                  o_mem_wdata = we_q ? i_v_wdata : '0;
                  o_v_wack    = we_q;
                  if (v_last) begin
                     state_nxt = we_q ? VDONE : VDRAIN;
                  end
               end
            end

            VDRAIN: begin
               o_s_stall = i_s_req;
               state_nxt = VDONE;
            end

            VDONE: begin
               o_s_stall = i_s_req;
               o_v_done  = 1'b1;
               state_nxt = IDLE;
            end

            default: begin
               state_nxt = IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_dmem_arbiter
// Self-checking bench for dmem_arbiter. Each vector is one clock cycle: the
// inputs are driven just after the rising edge and the outputs are compared
// on the falling edge. A small memory stub returns addr ^ 0x5A5A0000 one
// cycle after every read so vector read data can be predicted.
// ---------------------------------------------------------------------------
module tb_dmem_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int LW = 8;

   typedef struct packed {
      logic          rst;
      logic          stall;
      logic          s_req;
      logic          s_we;
      logic [31:0]   s_addr;
      logic [31:0]   s_wdata;
      logic          v_start;
      logic          v_we;
      logic [31:0]   v_base;
      logic [31:0]   v_stride;
      logic [7:0]    v_len;
      logic [31:0]   v_wdata;
   } in_t;

   typedef struct packed {
      logic          s_gnt;
      logic          s_stall;
      logic          mem_en;
      logic          mem_we;
      logic [31:0]   mem_addr;
      logic [31:0]   mem_wdata;
      logic          v_wack;
      logic          v_rvalid;
      logic [31:0]   v_rdata;
      logic          v_busy;
      logic          v_done;
   } out_t;

   typedef struct {
      logic strict;
      in_t  stim;
      out_t want;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          i_stall;
   logic          i_s_req;
   logic          i_s_we;
   logic [AW-1:0] i_s_addr;
   logic [DW-1:0] i_s_wdata;
   logic          o_s_gnt;
   logic          o_s_stall;
   logic          i_v_start;
   logic          i_v_we;
   logic [AW-1:0] i_v_base;
   logic [AW-1:0] i_v_stride;
   logic [LW-1:0] i_v_len;
   logic [DW-1:0] i_v_wdata;
   logic          o_v_wack;
   logic          o_v_rvalid;
   logic [DW-1:0] o_v_rdata;
   logic          o_v_busy;
   logic          o_v_done;
   logic          o_mem_en;
   logic          o_mem_we;
   logic [AW-1:0] o_mem_addr;
   logic [DW-1:0] o_mem_wdata;
   logic [DW-1:0] i_mem_rdata = '0;

   int            n_vec    = 0;
   int            n_bad    = 0;
   int            wack_cnt = 0;
   vec_t          vecs[$];
   string         names[$];

   dmem_arbiter #(
      .AW (AW),
      .DW (DW),
      .LW (LW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .i_stall     (i_stall),
      .i_s_req     (i_s_req),
      .i_s_we      (i_s_we),
      .i_s_addr    (i_s_addr),
      .i_s_wdata   (i_s_wdata),
      .o_s_gnt     (o_s_gnt),
      .o_s_stall   (o_s_stall),
      .i_v_start   (i_v_start),
      .i_v_we      (i_v_we),
      .i_v_base    (i_v_base),
      .i_v_stride  (i_v_stride),
      .i_v_len     (i_v_len),
      .i_v_wdata   (i_v_wdata),
      .o_v_wack    (o_v_wack),
      .o_v_rvalid  (o_v_rvalid),
      .o_v_rdata   (o_v_rdata),
      .o_v_busy    (o_v_busy),
      .o_v_done    (o_v_done),
      .o_mem_en    (o_mem_en),
      .o_mem_we    (o_mem_we),
      .o_mem_addr  (o_mem_addr),
      .o_mem_wdata (o_mem_wdata),
      .i_mem_rdata (i_mem_rdata)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   // Memory stub: read data is a fixed function of the address and appears
   // one cycle after the read was presented.
   function automatic logic [31:0] mem_f(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   always @(posedge clk) begin
      if (o_mem_en === 1'b1 && o_mem_we === 1'b0) begin
         i_mem_rdata <= mem_f(o_mem_addr);
      end
   end

   // Compact constructors for one cycle of stimulus and its expected outputs.
   function automatic in_t mi(input int r, input int st, input int sq, input int swe,
                              input int sa, input int swd, input int vs, input int vwe,
                              input int vb, input int vst, input int vl, input int vwd);
      in_t x;
      x.rst      = (r != 0);
      x.stall    = (st != 0);
      x.s_req    = (sq != 0);
      x.s_we     = (swe != 0);
      x.s_addr   = sa;
      x.s_wdata  = swd;
      x.v_start  = (vs != 0);
      x.v_we     = (vwe != 0);
      x.v_base   = vb;
      x.v_stride = vst;
      x.v_len    = 8'(vl);
      x.v_wdata  = vwd;
      return x;
   endfunction

   function automatic out_t mo(input int gnt, input int sst, input int en, input int we,
                               input int addr, input int wd, input int wack, input int rv,
                               input int rd, input int busy, input int done);
      out_t x;
      x.s_gnt     = (gnt != 0);
      x.s_stall   = (sst != 0);
      x.mem_en    = (en != 0);
      x.mem_we    = (we != 0);
      x.mem_addr  = addr;
      x.mem_wdata = wd;
      x.v_wack    = (wack != 0);
      x.v_rvalid  = (rv != 0);
      x.v_rdata   = rd;
      x.v_busy    = (busy != 0);
      x.v_done    = (done != 0);
      return x;
   endfunction

   function automatic string fmt(input out_t o);
      return $sformatf("gnt=%b sstall=%b en=%b we=%b addr=%h wd=%h wack=%b rv=%b rd=%h busy=%b done=%b",
                       o.s_gnt, o.s_stall, o.mem_en, o.mem_we, o.mem_addr, o.mem_wdata,
                       o.v_wack, o.v_rvalid, o.v_rdata, o.v_busy, o.v_done);
   endfunction

   task automatic addVec(input string nm, input int strict, input in_t s, input out_t w);
      vec_t v;
      v.strict = (strict != 0);
      v.stim   = s;
      v.want   = w;
      vecs.push_back(v);
      names.push_back(nm);
   endtask

   // Drive one cycle's worth of inputs.
   task automatic applyStimulus(input in_t s);
      rst        = s.rst;
      i_stall    = s.stall;
      i_s_req    = s.s_req;
      i_s_we     = s.s_we;
      i_s_addr   = s.s_addr;
      i_s_wdata  = s.s_wdata;
      i_v_start  = s.v_start;
      i_v_we     = s.v_we;
      i_v_base   = s.v_base;
      i_v_stride = s.v_stride;
      i_v_len    = s.v_len;
      i_v_wdata  = s.v_wdata;
   endtask

   // Compare the DUT outputs against one expected record. Address and read
   // data are only meaningful when en / rvalid are expected high, unless the
   // record is strict (right after reset, where every output must be zero).
   task automatic checkOutput(input string nm, input logic strict, input out_t want);
      out_t got;
      out_t cmp;
      got.s_gnt     = o_s_gnt;
      got.s_stall   = o_s_stall;
      got.mem_en    = o_mem_en;
      got.mem_we    = o_mem_we;
      got.mem_addr  = o_mem_addr;
      got.mem_wdata = o_mem_wdata;
      got.v_wack    = o_v_wack;
      got.v_rvalid  = o_v_rvalid;
      got.v_rdata   = o_v_rdata;
      got.v_busy    = o_v_busy;
      got.v_done    = o_v_done;
      cmp = got;
      if (!strict) begin
         if (!want.mem_en) cmp.mem_addr = want.mem_addr;
         if (!want.v_rvalid) cmp.v_rdata = want.v_rdata;
      end
      n_vec++;
      if (cmp !== want) begin
         n_bad++;
         $display("[TB] FAIL %s: got %s | want %s", nm, fmt(got), fmt(want));
      end
      if (got.v_wack === 1'b1) wack_cnt++;
   endtask

   task automatic runVec(input string nm, input int strict, input in_t s, input out_t w);
      @(posedge clk);
      #1;
      applyStimulus(s);
      @(negedge clk);
      checkOutput(nm, (strict != 0), w);
   endtask

   // Main sequence: reset, table of directed vectors, then the stall and
   // mid-burst reset corner cases written out cycle by cycle.
   initial begin
      applyStimulus(mi(1,0,0,0,0,0,0,0,0,0,0,0));
      repeat (3) @(posedge clk);

      addVec("rst_held",      1, mi(1,0,0,0,0,0,0,0,0,0,0,0),                   mo(0,0,0,0,0,0,0,0,0,0,0));
      addVec("rst_after",     1, mi(0,0,0,0,0,0,0,0,0,0,0,0),                   mo(0,0,0,0,0,0,0,0,0,0,0));
      addVec("coll1_scalar",  0, mi(0,0,1,0,32'h100,0,1,1,32'h2000,8,2,0),      mo(1,0,1,0,32'h100,0,0,0,0,0,0));
      addVec("scal_rd_100",   0, mi(0,0,1,0,32'h100,0,0,0,0,0,0,0),             mo(1,0,1,0,32'h100,0,0,0,0,0,0));
      addVec("scal_wr_200",   0, mi(0,0,1,1,32'h200,32'hCAFE_F00D,0,0,0,0,0,0), mo(1,0,1,1,32'h200,32'hCAFE_F00D,0,0,0,0,0));
      addVec("coll2_vec",     0, mi(0,0,1,0,32'h300,0,1,1,32'h2000,8,2,0),      mo(0,1,0,0,0,0,0,0,0,0,0));
      addVec("coll2_e0",      0, mi(0,0,1,0,32'h300,0,0,0,0,0,0,32'h11),        mo(0,1,1,1,32'h2000,32'h11,1,0,0,1,0));
      addVec("coll2_e1",      0, mi(0,0,1,0,32'h300,0,0,0,0,0,0,32'h22),        mo(0,1,1,1,32'h2008,32'h22,1,0,0,1,0));
      addVec("coll2_done",    0, mi(0,0,1,0,32'h300,0,0,0,0,0,0,0),             mo(0,1,0,0,0,0,0,0,0,1,1));
      addVec("coll2_scalar",  0, mi(0,0,1,0,32'h300,0,0,0,0,0,0,0),             mo(1,0,1,0,32'h300,0,0,0,0,0,0));
      addVec("vrd_start",     0, mi(0,0,0,0,0,0,1,0,32'h1000,4,4,0),            mo(0,0,0,0,0,0,0,0,0,0,0));
      addVec("vrd_e0",        0, mi(0,0,0,0,0,0,0,0,0,0,0,0),                   mo(0,0,1,0,32'h1000,0,0,0,0,1,0));
      addVec("vrd_e1_ignst",  0, mi(0,0,0,0,0,0,1,1,32'h7000,4,3,0),            mo(0,0,1,0,32'h1004,0,0,1,mem_f(32'h1000),1,0));
      addVec("vrd_e2",        0, mi(0,0,0,0,0,0,0,0,0,0,0,0),                   mo(0,0,1,0,32'h1008,0,0,1,mem_f(32'h1004),1,0));
      addVec("vrd_e3",        0, mi(0,0,0,0,0,0,0,0,0,0,0,0),                   mo(0,0,1,0,32'h100C,0,0,1,mem_f(32'h1008),1,0));
      addVec("vrd_drain",     0, mi(0,0,0,0,0,0,0,0,0,0,0,0),                   mo(0,0,0,0,0,0,0,1,mem_f(32'h100C),1,0));
      addVec("vrd_done",      0, mi(0,0,0,0,0,0,0,0,0,0,0,0),                   mo(0,0,0,0,0,0,0,0,0,1,1));
      addVec("vrd_idle",      0, mi(0,0,0,0,0,0,0,0,0,0,0,0),                   mo(0,0,0,0,0,0,0,0,0,0,0));
      addVec("len0_start",    0, mi(0,0,0,0,0,0,1,0,32'h3000,4,0,0),            mo(0,0,0,0,0,0,0,0,0,0,0));
      addVec("len0_done",     0, mi(0,0,0,0,0,0,0,0,0,0,0,0),                   mo(0,0,0,0,0,0,0,0,0,1,1));
      addVec("len0_idle",     0, mi(0,0,0,0,0,0,0,0,0,0,0,0),                   mo(0,0,0,0,0,0,0,0,0,0,0));
      addVec("idle_stall",    0, mi(0,1,1,0,32'h400,0,0,0,0,0,0,0),             mo(0,1,0,0,0,0,0,0,0,0,0));
      addVec("idle_unstall",  0, mi(0,0,0,0,0,0,0,0,0,0,0,0),                   mo(0,0,0,0,0,0,0,0,0,0,0));

      $display("[TB] applying %0d table vectors", vecs.size());
      for (int i = 0; i < vecs.size(); i++) begin
         runVec(names[i], vecs[i].strict, vecs[i].stim, vecs[i].want);
      end

      // Write burst, len 4, stalled for 3 cycles just before element 2.
      wack_cnt = 0;
      runVec("wst_start", 0, mi(0,0,0,0,0,0,1,1,32'h4000,4,4,0),  mo(0,0,0,0,0,0,0,0,0,0,0));
      runVec("wst_e0",    0, mi(0,0,0,0,0,0,0,0,0,0,0,32'hA0),    mo(0,0,1,1,32'h4000,32'hA0,1,0,0,1,0));
      runVec("wst_e1",    0, mi(0,0,0,0,0,0,0,0,0,0,0,32'hA1),    mo(0,0,1,1,32'h4004,32'hA1,1,0,0,1,0));
      for (int c = 0; c < 3; c++) begin
         runVec($sformatf("wst_stall%0d", c), 0, mi(0,1,1,0,32'h500,0,0,0,0,0,0,32'hA2),
                mo(0,1,0,0,0,0,0,0,0,1,0));
      end
      runVec("wst_e2",    0, mi(0,0,0,0,0,0,0,0,0,0,0,32'hA2),    mo(0,0,1,1,32'h4008,32'hA2,1,0,0,1,0));
      runVec("wst_e3",    0, mi(0,0,0,0,0,0,0,0,0,0,0,32'hA3),    mo(0,0,1,1,32'h400C,32'hA3,1,0,0,1,0));
      runVec("wst_done",  0, mi(0,0,0,0,0,0,0,0,0,0,0,0),         mo(0,0,0,0,0,0,0,0,0,1,1));
      n_vec++;
      if (wack_cnt != 4) begin
         n_bad++;
         $display("[TB] FAIL wst_wack_count: got %0d want 4", wack_cnt);
      end

      // Read burst, len 8, reset while element 1 is being issued.
      runVec("rrst_start", 0, mi(0,0,0,0,0,0,1,0,32'h5000,32'h10,8,0), mo(0,0,0,0,0,0,0,0,0,0,0));
      runVec("rrst_e0",    0, mi(0,0,0,0,0,0,0,0,0,0,0,0),             mo(0,0,1,0,32'h5000,0,0,0,0,1,0));
      @(posedge clk);
      #1;
      applyStimulus(mi(1,0,0,0,0,0,0,0,0,0,0,0));
      for (int c = 0; c < 4; c++) begin
         runVec($sformatf("rrst_quiet%0d", c), 1, mi(0,0,0,0,0,0,0,0,0,0,0,0),
                mo(0,0,0,0,0,0,0,0,0,0,0));
      end
      runVec("rrst_coll",  0, mi(0,0,1,0,32'h600,0,1,0,32'h8000,4,2,0), mo(1,0,1,0,32'h600,0,0,0,0,0,0));
      runVec("rrst_idle",  0, mi(0,0,0,0,0,0,0,0,0,0,0,0),             mo(0,0,0,0,0,0,0,0,0,0,0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
